// File: rtl/wave_channel_sequencer.sv
// wave_channel_sequencer: shadow/live configuration banks and per-channel enable FSMs
// for the dual-channel waveform datapath, with phase-safe commit and synchronized start.
module wave_channel_sequencer #(
    parameter int          NUM_CH_BITS = 1,
    parameter logic [15:0] DTCYC_RESET = 16'h8000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_sample_tick,
    input  logic                   i_wrap_a,
    input  logic                   i_wrap_b,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [NUM_CH_BITS-1:0] i_cmd_ch,
    input  logic [2:0]             i_cmd_addr,
    input  logic [31:0]            i_cmd_data,
    output logic                   o_ena,
    output logic                   o_enb,
    output logic [3:0]             o_mode_a,
    output logic [3:0]             o_mode_b,
    output logic [31:0]            o_freq_a,
    output logic [31:0]            o_freq_b,
    output logic [15:0]            o_dtcyc_a,
    output logic [15:0]            o_dtcyc_b,
    output logic signed [15:0]     o_phase_offs_a,
    output logic signed [15:0]     o_phase_offs_b,
    output logic                   o_busy_a,
    output logic                   o_busy_b,
    output logic                   o_done_a,
    output logic                   o_done_b,
    output logic                   o_pend_a,
    output logic                   o_pend_b
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

    logic [1:0]       w_wrap, w_pend, w_en, w_busy, w_done;
    logic [1:0][3:0]  w_mode;
    logic [1:0][31:0] w_freq;
    logic [1:0][15:0] w_dtcyc, w_phase;
    logic             w_accept, w_ctrl;

    assign w_wrap      = {i_wrap_b, i_wrap_a};
    // CTRL bypasses the pending-commit stall so a channel can always be stopped
    assign o_cmd_ready = !i_rst && (!w_pend[i_cmd_ch] || i_cmd_addr == 3'd5);
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_ctrl      = w_accept && i_cmd_addr == 3'd5;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        localparam logic [NUM_CH_BITS-1:0] CH = NUM_CH_BITS'(c);
        state_t      r_state, w_nstate;
        logic [3:0]  r_sh_mode, r_mode;
        logic [31:0] r_sh_freq, r_freq;
        logic [15:0] r_sh_dtcyc, r_dtcyc, r_sh_phase, r_phase, r_sh_cycles, r_cycles, r_cnt;
        logic        r_pend, r_en, r_done;
        logic        w_sel, w_wr, w_start, w_stop, w_wrap_run, w_hit, w_commit;
        logic [16:0] w_cnt_inc;

        assign w_sel      = i_cmd_ch == CH;
        assign w_wr       = w_accept && w_sel;
        assign w_stop     = w_ctrl && i_cmd_data[1] && (i_cmd_data[2] || w_sel);
        assign w_start    = w_ctrl && i_cmd_data[0] && !i_cmd_data[1] && (i_cmd_data[2] || w_sel);
        assign w_wrap_run = w_wrap[c] && r_state == S_RUN;
        assign w_cnt_inc  = {1'b0, r_cnt} + 17'd1;
        assign w_hit      = r_cycles != 16'd0 && w_cnt_inc >= {1'b0, r_cycles};
        // While running, the commit waits for a period boundary that STOP does not pre-empt
        assign w_commit   = r_pend && (r_state != S_RUN || (w_wrap[c] && !w_stop));

        always_comb begin
            w_nstate = r_state;
            w_nstate = w_stop                                  ? S_IDLE  :
                       w_start                                 ? S_ARMED :
                       (r_state == S_ARMED && i_sample_tick)   ? S_RUN   :
                       (w_wrap_run && w_hit)                   ? S_DONE  : r_state;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) r_state <= S_IDLE;
            else       r_state <= w_nstate;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_en        <= 1'b0;
                r_done      <= 1'b0;
                r_cnt       <= '0;
                r_pend      <= 1'b0;
                r_sh_mode   <= '0;
                r_sh_freq   <= '0;
                r_sh_dtcyc  <= DTCYC_RESET;
                r_sh_phase  <= '0;
                r_sh_cycles <= '0;
                r_mode      <= '0;
                r_freq      <= '0;
                r_dtcyc     <= DTCYC_RESET;
                r_phase     <= '0;
                r_cycles    <= '0;
            end else begin
                r_en   <= r_state == S_RUN;
                r_done <= !w_start && (r_done || w_nstate == S_DONE);
                r_cnt  <= (w_start || r_state == S_ARMED) ? '0 :
                          (w_wrap_run && !w_stop) ? (w_cnt_inc[16] ? 16'hFFFF : w_cnt_inc[15:0]) : r_cnt;
                r_pend <= w_commit ? 1'b0 : (r_pend || (w_wr && i_cmd_addr == 3'd6));
                if (w_wr && i_cmd_addr == 3'd0) r_sh_mode   <= i_cmd_data[3:0];
                if (w_wr && i_cmd_addr == 3'd1) r_sh_freq   <= i_cmd_data;
                if (w_wr && i_cmd_addr == 3'd2) r_sh_dtcyc  <= i_cmd_data[15:0];
                if (w_wr && i_cmd_addr == 3'd3) r_sh_phase  <= i_cmd_data[15:0];
                if (w_wr && i_cmd_addr == 3'd4) r_sh_cycles <= i_cmd_data[15:0];
                if (w_commit) begin
                    r_mode   <= r_sh_mode;
                    r_freq   <= r_sh_freq;
                    r_dtcyc  <= r_sh_dtcyc;
                    r_phase  <= r_sh_phase;
                    r_cycles <= r_sh_cycles;
                end
            end
        end

        assign w_pend[c]  = r_pend;
        assign w_en[c]    = r_en;
        assign w_done[c]  = r_done;
        assign w_busy[c]  = r_state == S_ARMED || r_state == S_RUN;
        assign w_mode[c]  = r_mode;
        assign w_freq[c]  = r_freq;
        assign w_dtcyc[c] = r_dtcyc;
        assign w_phase[c] = r_phase;
    end

    assign o_ena          = w_en[0];
    assign o_enb          = w_en[1];
    assign o_mode_a       = w_mode[0];
    assign o_mode_b       = w_mode[1];
    assign o_freq_a       = w_freq[0];
    assign o_freq_b       = w_freq[1];
    assign o_dtcyc_a      = w_dtcyc[0];
    assign o_dtcyc_b      = w_dtcyc[1];
    assign o_phase_offs_a = w_phase[0];
    assign o_phase_offs_b = w_phase[1];
    assign o_busy_a       = w_busy[0];
    assign o_busy_b       = w_busy[1];
    assign o_done_a       = w_done[0];
    assign o_done_b       = w_done[1];
    assign o_pend_a       = w_pend[0];
    assign o_pend_b       = w_pend[1];
endmodule

// File: tb/tb_wave_channel_sequencer.sv
// tb_wave_channel_sequencer: directed vector table for the documented scenarios, then
// randomized traffic checked against a behavioural model of the sequencer rules.
module tb_wave_channel_sequencer;
    logic        clk = 1'b0, rst = 1'b1, tick = 1'b0, wa = 1'b0, wb = 1'b0, v = 1'b0, ch = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] d = '0;
    logic        rdy, ena, enb, busy_a, busy_b, done_a, done_b, pend_a, pend_b;
    logic [3:0]  mode_a, mode_b;
    logic [31:0] freq_a, freq_b;
    logic [15:0] dt_a, dt_b;
    logic signed [15:0] ph_a, ph_b;
    int n_pass = 0, n_total = 0;

    wave_channel_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_sample_tick(tick), .i_wrap_a(wa), .i_wrap_b(wb),
        .i_cmd_valid(v), .o_cmd_ready(rdy), .i_cmd_ch(ch), .i_cmd_addr(addr), .i_cmd_data(d),
        .o_ena(ena), .o_enb(enb), .o_mode_a(mode_a), .o_mode_b(mode_b),
        .o_freq_a(freq_a), .o_freq_b(freq_b), .o_dtcyc_a(dt_a), .o_dtcyc_b(dt_b),
        .o_phase_offs_a(ph_a), .o_phase_offs_b(ph_b), .o_busy_a(busy_a), .o_busy_b(busy_b),
        .o_done_a(done_a), .o_done_b(done_b), .o_pend_a(pend_a), .o_pend_b(pend_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic v, ch;
        logic [2:0] addr;
        logic [31:0] data;
        logic tk, wa, wb;
        logic rdy, ena, enb, ba, bb, da, pa;
        logic [3:0] mode;
        logic [31:0] freq;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int iv, ich, iaddr, idata, itk, iwa, iwb,
                       input int erdy, eena, eenb, eba, ebb, eda, epa, emode, efreq);
        vec_t r;
        r.v = 1'(iv); r.ch = 1'(ich); r.addr = 3'(iaddr); r.data = 32'(idata);
        r.tk = 1'(itk); r.wa = 1'(iwa); r.wb = 1'(iwb);
        r.rdy = 1'(erdy); r.ena = 1'(eena); r.enb = 1'(eenb); r.ba = 1'(eba); r.bb = 1'(ebb);
        r.da = 1'(eda); r.pa = 1'(epa); r.mode = 4'(emode); r.freq = 32'(efreq);
        tbl.push_back(r);
    endtask

    // Behavioural model: shadow/live banks plus armed/running/done flags per channel
    logic [3:0]  m_sh_mode[2], m_mode[2];
    logic [31:0] m_sh_freq[2], m_freq[2];
    logic [15:0] m_sh_dt[2], m_dt[2], m_sh_ph[2], m_ph[2];
    int          m_sh_cyc[2], m_cyc[2], m_cnt[2];
    bit          m_pend[2], m_armed[2], m_run[2], m_done[2], m_en[2];

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            m_sh_mode[c] = '0; m_mode[c] = '0; m_sh_freq[c] = '0; m_freq[c] = '0;
            m_sh_dt[c] = 16'h8000; m_dt[c] = 16'h8000; m_sh_ph[c] = '0; m_ph[c] = '0;
            m_sh_cyc[c] = 0; m_cyc[c] = 0; m_cnt[c] = 0;
            m_pend[c] = 0; m_armed[c] = 0; m_run[c] = 0; m_done[c] = 0; m_en[c] = 0;
        end
    endtask

    function automatic bit m_ready();
        return !m_pend[ch] || addr == 3'd5;
    endfunction

    task automatic m_step();
        bit acc;
        acc = v && m_ready();
        for (int c = 0; c < 2; c++) begin
            bit sel, stop, start, wr, apply;
            sel   = (int'(ch) == c);
            stop  = acc && addr == 3'd5 && d[1] && (d[2] || sel);
            start = acc && addr == 3'd5 && d[0] && !d[1] && (d[2] || sel);
            wr    = (c == 0) ? wa : wb;
            apply = m_pend[c] && (!m_run[c] || (wr && !stop));
            m_en[c] = m_run[c];
            if (stop) begin
                m_armed[c] = 0; m_run[c] = 0;
            end else if (start) begin
                m_armed[c] = 1; m_run[c] = 0; m_done[c] = 0; m_cnt[c] = 0;
            end else if (m_armed[c] && tick) begin
                m_armed[c] = 0; m_run[c] = 1;
            end else if (m_run[c] && wr) begin
                if (m_cyc[c] != 0 && m_cnt[c] + 1 >= m_cyc[c]) begin
                    m_run[c] = 0; m_done[c] = 1;
                end
                m_cnt[c] = (m_cnt[c] < 65535) ? m_cnt[c] + 1 : 65535;
            end
            if (apply) begin
                m_mode[c] = m_sh_mode[c]; m_freq[c] = m_sh_freq[c]; m_dt[c] = m_sh_dt[c];
                m_ph[c] = m_sh_ph[c]; m_cyc[c] = m_sh_cyc[c]; m_pend[c] = 0;
            end else if (acc && sel && addr == 3'd6) m_pend[c] = 1;
            if (acc && sel) begin
                if (addr == 3'd0) m_sh_mode[c] = d[3:0];
                if (addr == 3'd1) m_sh_freq[c] = d;
                if (addr == 3'd2) m_sh_dt[c] = d[15:0];
                if (addr == 3'd3) m_sh_ph[c] = d[15:0];
                if (addr == 3'd4) m_sh_cyc[c] = int'(d[15:0]);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", rdy, 0);
        rst = 1'b0;
        #1;
        chk("reset ready after", rdy, 1);
        chk("reset ctl", {ena, enb, busy_a, busy_b, done_a, done_b, pend_a, pend_b}, 0);
        chk("reset cfg_a", {mode_a, freq_a, dt_a, ph_a}, {4'h0, 32'h0, 16'h8000, 16'h0});
        chk("reset cfg_b", {mode_b, freq_b, dt_b, ph_b}, {4'h0, 32'h0, 16'h8000, 16'h0});

        //   v ch ad data tk wa wb | rdy ena enb ba bb da pa mode freq
        add(1, 0, 1, 1000, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 6, 0,    0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1000);
        add(1, 0, 4, 3,    0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1000);
        add(1, 0, 6, 0,    0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1000);
        add(1, 0, 5, 1,    0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    1, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 1, 0,  1, 1, 0, 1, 0, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 1, 0,  1, 1, 0, 1, 0, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 1, 0,  1, 1, 0, 0, 0, 1, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 1, 0,  1, 0, 0, 0, 0, 1, 0, 0, 1000);
        add(1, 1, 5, 5,    0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    1, 0, 0,  1, 0, 0, 1, 1, 0, 0, 0, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  1, 1, 1, 1, 1, 0, 0, 0, 1000);
        add(1, 0, 0, 1,    0, 0, 0,  1, 1, 1, 1, 1, 0, 0, 0, 1000);
        add(1, 0, 6, 0,    0, 0, 0,  1, 1, 1, 1, 1, 0, 1, 0, 1000);
        add(1, 1, 1, 77,   0, 0, 0,  1, 1, 1, 1, 1, 0, 1, 0, 1000);
        add(1, 0, 0, 9,    0, 0, 0,  0, 1, 1, 1, 1, 0, 1, 0, 1000);
        add(0, 0, 0, 0,    0, 1, 0,  0, 1, 1, 1, 1, 0, 0, 1, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  1, 1, 1, 1, 1, 0, 0, 1, 1000);
        add(1, 0, 1, 2000, 0, 0, 0,  1, 1, 1, 1, 1, 0, 0, 1, 1000);
        add(1, 0, 6, 0,    0, 0, 0,  1, 1, 1, 1, 1, 0, 1, 1, 1000);
        add(1, 0, 5, 3,    0, 1, 0,  1, 1, 1, 0, 1, 0, 1, 1, 1000);
        add(0, 0, 0, 0,    0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 1, 2000);
        add(1, 0, 7, 5,    0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 1, 2000);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i].v; ch = tbl[i].ch; addr = tbl[i].addr; d = tbl[i].data;
            tick = tbl[i].tk; wa = tbl[i].wa; wb = tbl[i].wb;
            #1;
            chk($sformatf("row%0d ready", i), rdy, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d ctl", i), {ena, enb, busy_a, busy_b, done_a, pend_a},
                {tbl[i].ena, tbl[i].enb, tbl[i].ba, tbl[i].bb, tbl[i].da, tbl[i].pa});
            chk($sformatf("row%0d mode_a", i), mode_a, tbl[i].mode);
            chk($sformatf("row%0d freq_a", i), freq_a, tbl[i].freq);
        end

        v = 0; tick = 0; wa = 0; wb = 0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] ctl;
            v = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            addr = 3'($urandom_range(0, 7));
            ctl = 3'($urandom_range(0, 7));
            if (ctl[1] && $urandom_range(0, 3) != 0) ctl[1] = 1'b0;
            d = (addr == 3'd4) ? 32'($urandom_range(0, 5)) : (addr == 3'd5) ? {29'd0, ctl} : $urandom;
            tick = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 2) == 0);
            wb = ($urandom_range(0, 2) == 0);
            #1;
            chk("rnd ready", rdy, m_ready());
            m_step();
            @(posedge clk);
            #1;
            chk("rnd ctl", {ena, enb, busy_a, busy_b, done_a, done_b, pend_a, pend_b},
                {m_en[0], m_en[1], m_armed[0] | m_run[0], m_armed[1] | m_run[1],
                 m_done[0], m_done[1], m_pend[0], m_pend[1]});
            chk("rnd cfg_a", {mode_a, freq_a, dt_a, ph_a}, {m_mode[0], m_freq[0], m_dt[0], m_ph[0]});
            chk("rnd cfg_b", {mode_b, freq_b, dt_b, ph_b}, {m_mode[1], m_freq[1], m_dt[1], m_ph[1]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
